instr_loader: RTL and testbench
===============================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter: DEPTH_W, default 8, log2 of instruction-memory depth in 16-bit words.
REQ-002 Port: clk  input  1  single clock, all state on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  load request, sampled only in IDLE, DONE and ERR.
REQ-005 Port: rx_valid  input  1  byte stream valid.
REQ-006 Port: rx_data  input  8  byte stream data.
REQ-007 Port: rx_ready  output  1  loader accepts a byte this cycle.
REQ-008 Port: imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 Port: imem_addr  output  DEPTH_W  instruction-memory word index.
REQ-010 Port: imem_wd  output  16  instruction word to write.
REQ-011 Port: core_rst_n  output  1  active-low reset to the processor core, low while not loaded.
REQ-012 Port: busy  output  1  load in progress.
REQ-013 Port: done  output  1  last load completed with good checksum.
REQ-014 Port: err  output  1  last load failed.

Function
REQ-015 Byte transfer SHALL occur only on a cycle with rx_valid=1 and rx_ready=1; rx_valid gaps SHALL stall without state change.
REQ-016 rx_ready SHALL be 1 exactly in states HDR_HI, HDR_LO, DAT_HI, DAT_LO, CHK; 0 otherwise; sustained throughput 1 byte/cycle.
REQ-017 Frame format: count[15:8], count[7:0], then count words each as high byte then low byte, then one checksum byte.
REQ-018 States: IDLE, HDR_HI, HDR_LO, DAT_HI, DAT_LO, CHK, DONE, ERR.
REQ-019 IDLE/DONE/ERR with start=1 -> HDR_HI next cycle; busy=1, done=0, err=0, core_rst_n=0, word index=0, running checksum=0x00.
REQ-020 start SHALL be ignored in all other states.
REQ-021 HDR_HI on transfer: latch count high byte -> HDR_LO.
REQ-022 HDR_LO on transfer: count==0 -> CHK; count > 2^DEPTH_W -> ERR; else -> DAT_HI.
REQ-023 DAT_HI on transfer: latch high byte -> DAT_LO.
REQ-024 DAT_LO on transfer: next cycle imem_we=1 for exactly one cycle with imem_wd={high,low} and imem_addr=current index; index then increments.
REQ-025 DAT_LO transfer of word count-1 -> CHK; otherwise -> DAT_HI.
REQ-026 Index counter SHALL be DEPTH_W+1 bits; imem_addr = index[DEPTH_W-1:0]; count==2^DEPTH_W fills addresses 0..2^DEPTH_W-1 with no wrap overwrite.
REQ-027 Running checksum SHALL be XOR of every transferred byte from count[15:8] through last data byte.
REQ-028 CHK on transfer: byte == running checksum -> DONE, else -> ERR.
REQ-029 A write strobe pending from the final DAT_LO transfer SHALL still issue in the cycle CHK is entered.
REQ-030 DONE: done=1, busy=0, core_rst_n=1, held until start or reset.
REQ-031 ERR: err=1, busy=0, core_rst_n=0; words already written remain written.
REQ-032 imem_addr and imem_wd SHALL hold their last values when imem_we=0.

Reset
REQ-033 rst=0 SHALL immediately, without clock, force state IDLE, rx_ready=0, imem_we=0, imem_addr=0, imem_wd=0x0000, core_rst_n=0, busy=0, done=0, err=0, index=0, checksum=0x00.
REQ-034 Reset mid-load SHALL abandon the frame with no further writes; a pending write strobe SHALL be suppressed.
REQ-035 After rst deassertion the loader SHALL wait in IDLE for start.

Verification
REQ-036 Reset: hold rst=0 with random rx_valid/start -> all outputs at REQ-033 values, no imem_we.
REQ-037 Good load (DEPTH_W=8): start, bytes 00 02 12 34 AB CD 42 back-to-back -> writes addr0=0x1234, addr1=0xABCD, then done=1, core_rst_n=1, busy=0.
REQ-038 Bad checksum: same frame with last byte 43 -> both writes occur, err=1, done=0, core_rst_n=0.
REQ-039 Empty/oversize: frame 00 00 00 -> done=1, zero writes; frame 01 01 -> ERR after second byte, rx_ready=0, zero writes.
REQ-040 Stalls and restart: good frame with 1-3 cycle rx_valid gaps -> identical writes and done; then start in DONE -> core_rst_n=0, done=0 next cycle.
REQ-041 Reset mid-load: assert rst after byte 12 of good frame -> immediate reset values; subsequent full good frame loads correctly.

Source files
------------

// File: rtl/instr_loader.sv
// Instruction loader: receives a length-prefixed, XOR-checksummed byte frame and
// writes it into instruction memory as 16-bit words, holding the core in reset until loaded.
module instr_loader #(
  parameter int DEPTH_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  output logic               rx_ready,
  output logic               imem_we,
  output logic [DEPTH_W-1:0] imem_addr,
  output logic [15:0]        imem_wd,
  output logic               core_rst_n,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR_HI = 3'd1,
    S_HDR_LO = 3'd2,
    S_DAT_HI = 3'd3,
    S_DAT_LO = 3'd4,
    S_CHK    = 3'd5,
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  localparam logic [16:0] MAX_WORDS = 17'd1 << DEPTH_W;

  state_t             state_r;
  state_t             next_s;
  logic [15:0]        count_r;
  logic [7:0]         hi_byte_r;
  logic [DEPTH_W:0]   idx_r;
  logic [7:0]         csum_r;
  logic               rx_ready_r;
  logic               imem_we_r;
  logic [DEPTH_W-1:0] imem_addr_r;
  logic [15:0]        imem_wd_r;
  logic               core_rst_n_r;
  logic               busy_r;
  logic               done_r;
  logic               err_r;

  logic               xfer_s;
  logic               start_acc_s;
  logic [15:0]        count_s;
  logic               last_word_s;

  // States in which the loader consumes stream bytes
  function automatic logic accepts_bytes(input state_t s);
    case (s)
      S_HDR_HI, S_HDR_LO, S_DAT_HI, S_DAT_LO, S_CHK: accepts_bytes = 1'b1;
      default:                                     accepts_bytes = 1'b0;
    endcase
  endfunction

  assign xfer_s      = rx_valid && rx_ready_r;
  assign start_acc_s = start && ((state_r == S_IDLE) || (state_r == S_DONE) || (state_r == S_ERR));
  assign count_s     = {count_r[15:8], rx_data};
  assign last_word_s = ((17'(idx_r) + 17'd1) == {1'b0, count_r});

  // Next-state decode
  always_comb begin
    next_s = state_r;
    case (state_r)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_acc_s) next_s = S_HDR_HI;
        else             next_s = state_r;
      end
      S_HDR_HI: begin
        if (xfer_s) next_s = S_HDR_LO;
        else        next_s = state_r;
      end
      S_HDR_LO: begin
        if (!xfer_s)                              next_s = state_r;
        else if (count_s == 16'd0)                next_s = S_CHK;
        else if ({1'b0, count_s} > MAX_WORDS)     next_s = S_ERR;
        else                                      next_s = S_DAT_HI;
      end
      S_DAT_HI: begin
        if (xfer_s) next_s = S_DAT_LO;
        else        next_s = state_r;
      end
      S_DAT_LO: begin
        if (!xfer_s)         next_s = state_r;
        else if (last_word_s) next_s = S_CHK;
        else                 next_s = S_DAT_HI;
      end
      S_CHK: begin
        if (!xfer_s)                next_s = state_r;
        else if (rx_data == csum_r) next_s = S_DONE;
        else                        next_s = S_ERR;
      end
      default: next_s = S_IDLE;
    endcase
  end

  // State register with status outputs registered from the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= S_IDLE;
      rx_ready_r   <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      core_rst_n_r <= 1'b0;
    end else begin
      state_r      <= next_s;
      rx_ready_r   <= accepts_bytes(next_s);
      busy_r       <= accepts_bytes(next_s);
      done_r       <= (next_s == S_DONE);
      err_r        <= (next_s == S_ERR);
      core_rst_n_r <= (next_s == S_DONE);
    end
  end

  // Frame datapath: header count, word assembly, write strobe, index and checksum
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r     <= 16'd0;
      hi_byte_r   <= 8'd0;
      idx_r       <= '0;
      csum_r      <= 8'd0;
      imem_we_r   <= 1'b0;
      imem_addr_r <= '0;
      imem_wd_r   <= 16'd0;
    end else begin
      imem_we_r <= 1'b0;
      if (start_acc_s) begin
        idx_r  <= '0;
        csum_r <= 8'd0;
      end else if (xfer_s) begin
        // The checksum byte itself is compared, not accumulated
        if (state_r != S_CHK) csum_r <= csum_r ^ rx_data;
        else                  csum_r <= csum_r;
        case (state_r)
          S_HDR_HI: count_r[15:8] <= rx_data;
          S_HDR_LO: count_r[7:0]  <= rx_data;
          S_DAT_HI: hi_byte_r     <= rx_data;
          S_DAT_LO: begin
            imem_we_r   <= 1'b1;
            imem_addr_r <= idx_r[DEPTH_W-1:0];
            imem_wd_r   <= {hi_byte_r, rx_data};
            idx_r       <= idx_r + 1'b1;
          end
          default: hi_byte_r <= hi_byte_r;
        endcase
      end else begin
        csum_r <= csum_r;
      end
    end
  end

  assign rx_ready   = rx_ready_r;
  assign imem_we    = imem_we_r;
  assign imem_addr  = imem_addr_r;
  assign imem_wd    = imem_wd_r;
  assign core_rst_n = core_rst_n_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign err        = err_r;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: table of frames plus hand-written reset,
// boundary and restart sequences; writes are checked against a scoreboard queue.
module tb_instr_loader;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_ready;
  logic          imem_we;
  logic [DW-1:0] imem_addr;
  logic [15:0]   imem_wd;
  logic          core_rst_n;
  logic          busy;
  logic          done;
  logic          err;

  instr_loader #(.DEPTH_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wd(imem_wd),
    .core_rst_n(core_rst_n), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];

  typedef struct {
    logic [0:7][7:0] b;
    int              n;
    bit              gaps;
    bit              exp_done;
  } frame_t;

  frame_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual addr=%0h data=%0h expected no write", imem_addr, imem_wd);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        chk("write_addr", 32'(imem_addr), 32'(e[23:16]));
        chk("write_data", 32'(imem_wd), 32'(e[15:0]));
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    chk({tag, "_we"}, 32'(imem_we), 32'd0);
    chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
    chk({tag, "_wd"}, 32'(imem_wd), 32'd0);
    chk({tag, "_core_rst_n"}, 32'(core_rst_n), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_done", 32'(done), 32'd0);
    chk("start_err", 32'(err), 32'd0);
    chk("start_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("start_rx_ready", 32'(rx_ready), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    t = 0;
    while (!rx_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      checks++;
      errors++;
      $display("FAIL rx_ready_timeout actual=0 expected=1 byte=%0h", b);
    end else begin
      @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  task automatic run_frame(input frame_t f, input string tag);
    int cnt;
    do_start();
    cnt = {f.b[0], f.b[1]};
    for (int i = 0; i < f.n; i++) begin
      if (i >= 3 && (i % 2) == 1 && cnt != 0 && cnt <= (1 << DW) && ((i - 3) / 2) < cnt)
        exp_q.push_back({8'((i - 3) / 2), f.b[i-1], f.b[i]});
      send_byte(f.b[i], f.gaps ? int'($urandom_range(1, 3)) : 0);
    end
    @(negedge clk);
    chk({tag, "_done"}, 32'(done), 32'(f.exp_done));
    chk({tag, "_err"}, 32'(err), 32'(!f.exp_done));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_core_rst_n"}, 32'(core_rst_n), 32'(f.exp_done));
    chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    chk({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    frame_t good;
    logic [7:0] cs;

    tbl[0] = '{b: {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42, 8'h00}, n: 7, gaps: 1'b0, exp_done: 1'b1};
    tbl[1] = '{b: {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43, 8'h00}, n: 7, gaps: 1'b0, exp_done: 1'b0};
    tbl[2] = '{b: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, n: 3, gaps: 1'b0, exp_done: 1'b1};
    tbl[3] = '{b: {8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, n: 2, gaps: 1'b0, exp_done: 1'b0};
    tbl[4] = '{b: {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42, 8'h00}, n: 7, gaps: 1'b1, exp_done: 1'b1};
    tbl[5] = '{b: {8'h00, 8'h01, 8'hFF, 8'h00, 8'hFE, 8'h00, 8'h00, 8'h00}, n: 5, gaps: 1'b1, exp_done: 1'b1};
    tbl[6] = '{b: {8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, n: 3, gaps: 1'b0, exp_done: 1'b0};
    good = tbl[0];

    // Reset held with random activity on the inputs
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rx_valid = 1'($urandom_range(0, 1));
      start    = 1'($urandom_range(0, 1));
      rx_data  = 8'($urandom_range(0, 255));
      #1;
      if (i == 7) check_idle_outputs("reset_hold");
      else chk("reset_hold_we", 32'(imem_we), 32'd0);
    end
    rx_valid = 1'b0;
    start    = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_busy", 32'(busy), 32'd0);
    chk("post_reset_rx_ready", 32'(rx_ready), 32'd0);

    for (int k = 0; k < 7; k++) run_frame(tbl[k], $sformatf("frame%0d", k));

    // Restart from DONE after a stalled good load
    run_frame(tbl[4], "stall_again");
    do_start();
    chk("restart_done_cleared", 32'(done), 32'd0);

    // Reset mid-load after byte 12
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    #1;
    rst = 1'b0;
    #1;
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_rx_ready", 32'(rx_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("midreset");
    run_frame(good, "after_midreset");

    // Full-depth frame: 256 words fill every address exactly once
    do_start();
    cs = 8'h01 ^ 8'h00;
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    for (int w = 0; w < 256; w++) begin
      exp_q.push_back({8'(w), 8'(w), ~8'(w)});
      cs = cs ^ 8'(w) ^ ~8'(w);
      send_byte(8'(w), 0);
      send_byte(~8'(w), 0);
    end
    send_byte(cs, 0);
    @(negedge clk);
    chk("full_done", 32'(done), 32'd1);
    chk("full_pending_writes", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    chk("addr_hold", 32'(imem_addr), 32'hFF);
    chk("wd_hold", 32'(imem_wd), 32'hFF00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end
endmodule
